// File: rtl/debug_pkg.sv
// Shared definitions for the MIPS debug path: serializer state encoding,
// default geometry, counter sizing helper and the database field map.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATO = 3'd1,
    SEND      = 3'd2,
    WAIT_TX   = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int LONGITUD_INSTRUCCION_DEF = 32;
  localparam int NB_DATA_DEF              = 8;
  localparam int CANT_BITS_CONTROL_DEF    = 4;
  localparam int CANT_CAMPOS_DEF          = 12;
  localparam int BYTES                    = LONGITUD_INSTRUCCION_DEF / NB_DATA_DEF;

  // Meaning of each database field index, in dump order.
  typedef enum logic [CANT_BITS_CONTROL_DEF-1:0] {
    CAMPO_PC           = 4'd0,
    CAMPO_INSTRUCCION  = 4'd1,
    CAMPO_REG_RS       = 4'd2,
    CAMPO_REG_RT       = 4'd3,
    CAMPO_ALU_RESULT   = 4'd4,
    CAMPO_MEM_DATO     = 4'd5,
    CAMPO_WB_DATO      = 4'd6,
    CAMPO_CTRL_EX      = 4'd7,
    CAMPO_CTRL_MEM     = 4'd8,
    CAMPO_CTRL_WB      = 4'd9,
    CAMPO_HAZARD_FLAGS = 4'd10,
    CAMPO_CYCLE_COUNT  = 4'd11
  } campo_t;

  // Bits needed to index 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/selector_byte.sv
// Combinational byte picker: index 0 selects the most significant byte.
module selector_byte
  import debug_pkg::*;
#(
  parameter int W      = 32,
  parameter int NB     = 8,
  parameter int NB_IDX = clogb2(W / NB)
) (
  input  logic [W-1:0]      word,
  input  logic [NB_IDX-1:0] idx,
  output logic [NB-1:0]     dato_byte
);

  always_comb begin
    dato_byte = word[W-1-int'(idx)*NB -: NB];
  end

endmodule

// File: rtl/database_serializer.sv
// Walks the database fields, latches each word and streams it MSB byte first
// to the UART with a start/done handshake.
module database_serializer
  import debug_pkg::*;
#(
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int CANT_BITS_CONTROL    = 4,
  parameter int CANT_CAMPOS          = 12,
  parameter int NB_DATA              = 8
) (
  input  logic                            i_clock,
  input  logic                            i_soft_reset,
  input  logic                            i_start,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_dato,
  output logic [CANT_BITS_CONTROL-1:0]    o_control,
  output logic                            o_tx_start,
  output logic [NB_DATA-1:0]              o_tx_data,
  input  logic                            i_tx_done,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int N_BYTES      = LONGITUD_INSTRUCCION / NB_DATA;
  localparam int NB_BYTE_CNT  = clogb2(N_BYTES);
  localparam int NB_FIELD_CNT = clogb2(CANT_CAMPOS);
  localparam logic [NB_BYTE_CNT-1:0]  LAST_BYTE  = NB_BYTE_CNT'(N_BYTES - 1);
  localparam logic [NB_FIELD_CNT-1:0] LAST_FIELD = NB_FIELD_CNT'(CANT_CAMPOS - 1);

  state_t                            state;
  logic [NB_FIELD_CNT-1:0]           field;
  logic [NB_BYTE_CNT-1:0]            byte_idx;
  logic [LONGITUD_INSTRUCCION-1:0]   word;
  logic [NB_DATA-1:0]                byte_sel;

  selector_byte #(
    .W      (LONGITUD_INSTRUCCION),
    .NB     (NB_DATA),
    .NB_IDX (NB_BYTE_CNT)
  ) u_selector_byte (
    .word      (word),
    .idx       (byte_idx),
    .dato_byte (byte_sel)
  );

  // NOTE: every register here, word included, is a plain flop (no RAM), so it
  // is cleared by reset; all state updates use <= so the case arms read the
  // pre-edge values of their neighbours.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state      <= IDLE;
      field      <= '0;
      byte_idx   <= '0;
      word       <= '0;
      o_control  <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_control <= '0;
            field     <= '0;
            o_busy    <= 1'b1;
            state     <= WAIT_DATO;
          end
        end
        WAIT_DATO: begin
          word     <= i_dato;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= byte_sel;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= SEND;
            end else if (field != LAST_FIELD) begin
              field     <= field + 1'b1;
              o_control <= CANT_BITS_CONTROL'(field + 1'b1);
              state     <= WAIT_DATO;
            end else begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          o_busy    <= 1'b0;
          o_control <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_database_serializer.sv
// Directed bench: database and UART models, byte-stream scoreboard, reset,
// latency, protocol abuse, mid-dump reset, recovery and back-to-back dumps.
module tb_database_serializer;
  import debug_pkg::*;

  localparam int W        = 32;
  localparam int NB       = 8;
  localparam int NCTL     = 4;
  localparam int N_CAMPOS = int'(CAMPO_CYCLE_COUNT) + 1;
  localparam int N_BYTES  = N_CAMPOS * (W / NB);

  logic            clk = 1'b0;
  logic            i_soft_reset = 1'b0;
  logic            i_start = 1'b0;
  logic [W-1:0]    i_dato = '0;
  logic            i_tx_done = 1'b0;
  logic [NCTL-1:0] o_control;
  logic            o_tx_start;
  logic [NB-1:0]   o_tx_data;
  logic            o_busy;
  logic            o_done;

  database_serializer #(
    .LONGITUD_INSTRUCCION (W),
    .CANT_BITS_CONTROL    (NCTL),
    .CANT_CAMPOS          (N_CAMPOS),
    .NB_DATA              (NB)
  ) dut (
    .i_clock      (clk),
    .i_soft_reset (i_soft_reset),
    .i_start      (i_start),
    .i_dato       (i_dato),
    .o_control    (o_control),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .i_tx_done    (i_tx_done),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int uart_cnt = 0;
  bit abuse = 1'b0;
  bit echo_done = 1'b0;
  bit prev_done = 1'b0;
  logic spur_req = 1'b0;
  logic [NB-1:0]   rx_q[$];
  logic [NCTL-1:0] ctl_q[$];
  logic            busy_after_done_q[$];

  // Monitor plus database and UART models, all on the falling edge.
  always @(negedge clk) begin
    if (o_tx_start) begin
      rx_q.push_back(o_tx_data);
      ctl_q.push_back(o_control);
    end
    if (prev_done) busy_after_done_q.push_back(o_busy);
    prev_done = o_done;
    if (o_done) done_cnt++;
    i_tx_done = spur_req | echo_done;
    echo_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        i_tx_done = 1'b1;
        echo_done = abuse;
      end
    end
    if (o_tx_start) uart_cnt = 10;
    i_dato = (abuse && uart_cnt > 0) ? 32'hDEAD_BEEF : 32'hA0B0_C000 + 32'(o_control);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = 32'hA0B0_C000 + 32'((n % N_BYTES) / 4);
    return 8'(w >> (8 * (3 - (n % 4))));
  endfunction

  task automatic check_stream(input string tag, input int n_exp);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(n_exp));
    for (int i = 0; i < rx_q.size() && i < n_exp; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_byte(i)));
      check($sformatf("%s_ctl%0d", tag, i), 32'(ctl_q[i]), 32'((i % N_BYTES) / 4));
    end
  endtask

  task automatic wait_done(input string tag, input int target, input int budget, input bit poke);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_cnt >= target) break;
      if (poke) i_start = ((c % 61) == 30);
    end
    if (poke) i_start = 1'b0;
    check({tag, "_done_wait"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (rx_q.size() >= n) break;
    end
    check({tag, "_bytes_wait"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic clear_logs();
    rx_q.delete();
    ctl_q.delete();
    busy_after_done_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_control"}, 32'(o_control), 32'd0);
    check({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  int base_done;

  initial begin
    // Reset held: everything at zero.
    repeat (3) tick();
    check_idle_outputs("reset");

    // Released with no start: stays idle.
    i_soft_reset = 1'b1;
    repeat (20) tick();
    check("idle_no_tx", 32'(rx_q.size()), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);

    // Full dump with latency check.
    clear_logs();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("lat_busy_k", 32'(o_busy), 32'd1);
    check("lat_txs_k", 32'(o_tx_start), 32'd0);
    tick();
    check("lat_txs_k1", 32'(o_tx_start), 32'd0);
    tick();
    check("lat_txs_k2", 32'(o_tx_start), 32'd1);
    check("lat_data_k2", 32'(o_tx_data), 32'hA0);
    wait_done("dump1", 1, 2000, 1'b0);
    repeat (3) tick();
    check_stream("dump1", N_BYTES);
    check("dump1_done_cnt", 32'(done_cnt), 32'd1);
    check("dump1_busy_after", 32'(o_busy), 32'd0);
    check("dump1_control_after", 32'(o_control), 32'd0);

    // Protocol abuse: spurious done in IDLE, start pokes, echoed dones, data noise.
    clear_logs();
    abuse = 1'b1;
    @(posedge clk); #1 spur_req = 1'b1;
    @(posedge clk); #1 spur_req = 1'b0;
    repeat (2) tick();
    check("abuse_idle_busy", 32'(o_busy), 32'd0);
    check("abuse_idle_tx", 32'(rx_q.size()), 32'd0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("abuse", 2, 2000, 1'b1);
    repeat (15) tick();
    check_stream("abuse", N_BYTES);
    check("abuse_done_cnt", 32'(done_cnt), 32'd2);
    check("abuse_busy_after", 32'(o_busy), 32'd0);
    abuse = 1'b0;

    // Reset during field 5, byte 2.
    clear_logs();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_bytes("midrst", 5 * 4 + 3, 2000);
    check("midrst_ctl_before", 32'(o_control), 32'd5);
    i_soft_reset = 1'b0;
    #1;
    check_idle_outputs("midrst");
    base_done = done_cnt;
    repeat (3) tick();
    i_soft_reset = 1'b1;
    repeat (15) tick();
    check("midrst_no_done", 32'(done_cnt), 32'(base_done));
    check("midrst_busy_idle", 32'(o_busy), 32'd0);

    // Recovery: restarts at field 0.
    clear_logs();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("recov", base_done + 1, 2000, 1'b0);
    repeat (3) tick();
    check_stream("recov", N_BYTES);

    // Back-to-back: start held across DONE.
    clear_logs();
    base_done = done_cnt;
    i_start = 1'b1;
    wait_done("b2b", base_done + 2, 4000, 1'b0);
    i_start = 1'b0;
    repeat (15) tick();
    check_stream("b2b", 2 * N_BYTES);
    check("b2b_done_cnt", 32'(done_cnt), 32'(base_done + 2));
    check("b2b_logs", 32'(busy_after_done_q.size()), 32'd2);
    for (int i = 0; i < busy_after_done_q.size(); i++)
      check($sformatf("b2b_busy_after_done%0d", i), 32'(busy_after_done_q[i]), 32'd0);
    check("b2b_busy_end", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/database_serializer.md
Name: database_serializer

Overview:
- Downstream consumer of the `database` debug-capture block in the MIPS debug path.
- On a dump request it steps `database` through each field index on `o_control` and latches the returned 32-bit `i_dato`.
- Each word is split into bytes, MSB first, and every byte is handed to the UART transmitter with a start/done handshake.
- The host receives every pipeline latch (PC, instruction, registers, control flags, cycle count) as a fixed-length byte stream.

Parameters:
- `LONGITUD_INSTRUCCION`, 32, width of `i_dato`; must be a multiple of `NB_DATA`.
- `CANT_BITS_CONTROL`, 4, width of the field selector driven to `database.i_control`.
- `CANT_CAMPOS`, 12, number of fields dumped (indices 0..`CANT_CAMPOS`-1); must be ≤ 2^`CANT_BITS_CONTROL`.
- `NB_DATA`, 8, UART byte width.

Ports:
- `i_clock` in 1: single system clock, rising edge.
- `i_soft_reset` in 1: reset, asynchronous, active-low (0 = reset).
- `i_start` in 1: dump request; sampled only in IDLE.
- `i_dato` in `LONGITUD_INSTRUCCION`: field data from `database.o_dato`; registered in `database`, valid one cycle after `o_control` changes.
- `o_control` out `CANT_BITS_CONTROL`: field index to `database.i_control`.
- `o_tx_start` out 1: one-cycle pulse; the UART latches `o_tx_data`.
- `o_tx_data` out `NB_DATA`: byte to transmit; held stable until the next `o_tx_start`.
- `i_tx_done` in 1: one-cycle pulse from the UART when the byte has been sent.
- `o_busy` out 1: high from start acceptance until completion.
- `o_done` out 1: one-cycle pulse when the last byte's `i_tx_done` has been accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; `o_control`=0; `o_tx_start`=0; `o_tx_data`=0; `o_busy`=0; `o_done`=0; field counter, byte counter and word register cleared.
- States: IDLE, WAIT_DATO, SEND, WAIT_TX, DONE.
- IDLE: if `i_start`=1 at edge k → `o_control`<=0, field=0, `o_busy`<=1, go to WAIT_DATO. Otherwise hold.
- WAIT_DATO (exactly one cycle): word<=`i_dato`, byte=0, go to SEND.
- SEND (one cycle):
  - `o_tx_start`<=1.
  - `o_tx_data`<=word[W-1-byte*NB_DATA -: NB_DATA], i.e. MSB byte first.
  - Go to WAIT_TX. `o_tx_start` deasserts at the next edge.
- First `o_tx_start` is high in the cycle after edge k+2 (3-cycle latency from start acceptance).
- WAIT_TX: hold until `i_tx_done`=1, then:
  - byte < BYTES-1 (BYTES = `LONGITUD_INSTRUCCION`/`NB_DATA`): byte++, go to SEND.
  - else if field < `CANT_CAMPOS`-1: field++, `o_control`<=field+1, go to WAIT_DATO.
  - else: go to DONE.
- DONE (one cycle): `o_done`=1, `o_busy`<=0, `o_control`<=0, go to IDLE.
- Total bytes per dump: `CANT_CAMPOS`*BYTES = 48 by default. `o_control` is monotonic 0..`CANT_CAMPOS`-1 during a dump.
- `i_start` outside IDLE (including DONE) is ignored; no queuing.
- `i_tx_done` outside WAIT_TX is ignored.
- `i_tx_done` on the same edge that enters WAIT_TX is not counted; the first counted `i_tx_done` is on the edge after entry.
- Word register is loaded only in WAIT_DATO; changes on `i_dato` mid-word do not affect the bytes sent.
- Reset mid-dump: immediate return to the reset values; no `o_done`; the next `i_start` begins again at field 0.
- A UART that never returns `i_tx_done` leaves the block in WAIT_TX indefinitely; there is no timeout. Recovery is by reset.

Decomposition:
- Shared package (`debug_pkg`) holds:
  - state encoding localparams (IDLE=0, WAIT_DATO=1, SEND=2, WAIT_TX=3, DONE=4, 3 bits);
  - BYTES derived constant;
  - the `clogb2` function used to size the byte and field counters.
- The `database` field map (index meanings) also lives in `debug_pkg` so the host decoder and the bench share it.
- One natural sub-module: `selector_byte`, a combinational word/byte-index → byte mux, reused by the upcoming instruction-memory loader.

Test Plan:
- Reset checks:
  - Hold `i_soft_reset`=0 → all outputs 0.
  - Release, then hold `i_start`=0 for 20 cycles → no `o_tx_start`, `o_busy`=0.
- Full dump:
  - Bench `database` model returns `i_dato`=32'hA0B0C000+control one cycle after `o_control` changes.
  - UART model pulses `i_tx_done` 10 cycles after each `o_tx_start`.
  - Pulse `i_start` → 48 bytes in order A0,B0,C0,00,A0,B0,C0,01,…,A0,B0,C0,0B.
  - `o_control` steps 0..11; exactly one `o_done`; `o_busy` low afterwards.
- Latency: `i_start` accepted at edge k → `o_tx_start` high in the cycle after edge k+2 with `o_tx_data`=8'hA0.
- Protocol abuse:
  - `i_start` pulses during a dump and spurious `i_tx_done` while in SEND/IDLE → byte count still 48; no duplicated or skipped bytes.
- Reset mid-operation: assert `i_soft_reset`=0 during field 5, byte 2 → outputs return to reset values at once, no `o_done`.
- Recovery: a new `i_start` after reset → stream restarts at field 0 with byte A0.
- Back-to-back: `i_start` held high across DONE → ignored in DONE; a second dump starts on the IDLE cycle; two complete 48-byte streams with two `o_done` pulses.
